// File: rtl/ddr4_cas_scheduler.sv
// Two-requester RD/WR CAS arbiter with per-bank-group tCCD, tWTR and RD->WR turnaround gating.
// Handshake: a request is consumed on a cycle where reqN_valid & reqN_ready; at most one ready per cycle.
module ddr4_cas_scheduler #(
  parameter int  NUM_BG  = 4,
  parameter int  TCCD_S  = 4,
  parameter int  BL_HALF = 4,
  parameter int  CNT_W   = 6,
  localparam int BG_W    = $clog2(NUM_BG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_en,
  input  logic [4:0]      cfg_cl,
  input  logic [4:0]      cfg_cwl,
  input  logic [3:0]      cfg_tccd_l,
  input  logic [3:0]      cfg_twtr_s,
  input  logic [3:0]      cfg_twtr_l,
  input  logic            req0_valid,
  input  logic            req0_write,
  input  logic [BG_W-1:0] req0_bg,
  input  logic [1:0]      req0_ba,
  input  logic [9:0]      req0_col,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic            req1_write,
  input  logic [BG_W-1:0] req1_bg,
  input  logic [1:0]      req1_ba,
  input  logic [9:0]      req1_col,
  output logic            req1_ready,
  output logic            cas_valid,
  output logic            cas_write,
  output logic [BG_W-1:0] cas_bg,
  output logic [1:0]      cas_ba,
  output logic [9:0]      cas_col,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {ST_OFF, ST_LOAD, ST_ACTIVE} state_e;

  state_e state_q, state_d;
  logic   cfg_en_q;
  logic   rr_q, rr_d;

  logic [CNT_W-1:0] tccd_l_q, wtr_s_q, wtr_l_q, rtw_q;
  logic [CNT_W-1:0] ccd_s_q, ccd_s_d;
  logic [CNT_W-1:0] wtr_any_q, wtr_any_d;
  logic [CNT_W-1:0] rtw_cnt_q, rtw_cnt_d;
  logic [CNT_W-1:0] ccd_bg_q [NUM_BG];
  logic [CNT_W-1:0] ccd_bg_d [NUM_BG];
  logic [CNT_W-1:0] wtr_bg_q [NUM_BG];
  logic [CNT_W-1:0] wtr_bg_d [NUM_BG];

  logic            cas_valid_q, cas_write_q;
  logic [BG_W-1:0] cas_bg_q;
  logic [1:0]      cas_ba_q;
  logic [9:0]      cas_col_q;

  logic [CNT_W-1:0] cwl_ext, rtw_sum, rtw_calc, wtr_s_calc, wtr_l_calc;
  logic             can_issue, elig0, elig1, grant0, grant1, gnt;
  logic             g_write;
  logic [BG_W-1:0]  g_bg;
  logic [1:0]       g_ba;
  logic [9:0]       g_col;
  logic             busy_c;

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cmax(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Turnaround is clamped to 1 when CWL exceeds CL+BL/2+2 (subtraction would wrap).
  assign cwl_ext    = CNT_W'(cfg_cwl);
  assign rtw_sum    = CNT_W'(cfg_cl) + CNT_W'(BL_HALF + 2);
  assign rtw_calc   = (rtw_sum > cwl_ext) ? rtw_sum - cwl_ext : CNT_W'(1);
  assign wtr_s_calc = cwl_ext + CNT_W'(BL_HALF) + CNT_W'(cfg_twtr_s);
  assign wtr_l_calc = cwl_ext + CNT_W'(BL_HALF) + CNT_W'(cfg_twtr_l);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:    if (cfg_en && !cfg_en_q) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_ACTIVE;
      ST_ACTIVE: if (!cfg_en) state_d = ST_OFF;
      default:   state_d = ST_OFF;
    endcase
  end

  assign can_issue = (state_q == ST_ACTIVE) && cfg_en && !rst;

  assign elig0 = req0_valid && (ccd_s_q == '0) && (ccd_bg_q[req0_bg] == '0) &&
                 (req0_write ? (rtw_cnt_q == '0) : ((wtr_any_q == '0) && (wtr_bg_q[req0_bg] == '0)));
  assign elig1 = req1_valid && (ccd_s_q == '0) && (ccd_bg_q[req1_bg] == '0) &&
                 (req1_write ? (rtw_cnt_q == '0) : ((wtr_any_q == '0) && (wtr_bg_q[req1_bg] == '0)));

  assign grant0 = can_issue && elig0 && (!elig1 || !rr_q);
  assign grant1 = can_issue && elig1 && (!elig0 || rr_q);
  assign gnt    = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign g_write = grant1 ? req1_write : req0_write;
  assign g_bg    = grant1 ? req1_bg    : req0_bg;
  assign g_ba    = grant1 ? req1_ba    : req0_ba;
  assign g_col   = grant1 ? req1_col   : req0_col;

  assign rr_d = grant0 ? 1'b1 : (grant1 ? 1'b0 : rr_q);

  // A new load never shortens a window that is still running.
  always_comb begin
    ccd_s_d   = dec(ccd_s_q);
    wtr_any_d = dec(wtr_any_q);
    rtw_cnt_d = dec(rtw_cnt_q);
    for (int g = 0; g < NUM_BG; g++) begin
      ccd_bg_d[g] = dec(ccd_bg_q[g]);
      wtr_bg_d[g] = dec(wtr_bg_q[g]);
    end
    if (gnt) begin
      ccd_s_d        = cmax(ccd_s_d, CNT_W'(TCCD_S - 1));
      ccd_bg_d[g_bg] = cmax(ccd_bg_d[g_bg], tccd_l_q - CNT_W'(1));
      if (g_write) begin
        wtr_bg_d[g_bg] = cmax(wtr_bg_d[g_bg], wtr_l_q - CNT_W'(1));
        wtr_any_d      = cmax(wtr_any_d, wtr_s_q - CNT_W'(1));
      end else begin
        rtw_cnt_d = cmax(rtw_cnt_d, rtw_q - CNT_W'(1));
      end
    end
  end

  always_comb begin
    busy_c = (ccd_s_q != '0) || (wtr_any_q != '0) || (rtw_cnt_q != '0);
    for (int g = 0; g < NUM_BG; g++) begin
      busy_c = busy_c || (ccd_bg_q[g] != '0) || (wtr_bg_q[g] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      cfg_en_q    <= 1'b0;
      rr_q        <= 1'b0;
      tccd_l_q    <= '0;
      wtr_s_q     <= '0;
      wtr_l_q     <= '0;
      rtw_q       <= '0;
      ccd_s_q     <= '0;
      wtr_any_q   <= '0;
      rtw_cnt_q   <= '0;
      ccd_bg_q    <= '{default: '0};
      wtr_bg_q    <= '{default: '0};
      cas_valid_q <= 1'b0;
      cas_write_q <= 1'b0;
      cas_bg_q    <= '0;
      cas_ba_q    <= '0;
      cas_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      cfg_en_q    <= cfg_en;
      rr_q        <= rr_d;
      ccd_s_q     <= ccd_s_d;
      wtr_any_q   <= wtr_any_d;
      rtw_cnt_q   <= rtw_cnt_d;
      ccd_bg_q    <= ccd_bg_d;
      wtr_bg_q    <= wtr_bg_d;
      cas_valid_q <= gnt;
      if (state_q == ST_LOAD) begin
        tccd_l_q <= CNT_W'(cfg_tccd_l);
        wtr_s_q  <= wtr_s_calc;
        wtr_l_q  <= wtr_l_calc;
        rtw_q    <= rtw_calc;
      end
      if (gnt) begin
        cas_write_q <= g_write;
        cas_bg_q    <= g_bg;
        cas_ba_q    <= g_ba;
        cas_col_q   <= g_col;
      end
    end
  end

  assign cas_valid = cas_valid_q;
  assign cas_write = cas_write_q;
  assign cas_bg    = cas_bg_q;
  assign cas_ba    = cas_ba_q;
  assign cas_col   = cas_col_q;
  assign busy      = busy_c;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr4_cas_scheduler.sv
// Bench for ddr4_cas_scheduler: time-based reference model (earliest-free cycle per resource)
// plus directed spacing checks.
module tb_ddr4_cas_scheduler;

  localparam int TCCD_S  = 4;
  localparam int BL_HALF = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cfg_en;
  logic [4:0] cfg_cl, cfg_cwl;
  logic [3:0] cfg_tccd_l, cfg_twtr_s, cfg_twtr_l;
  logic       req0_valid, req0_write, req0_ready;
  logic [1:0] req0_bg, req0_ba;
  logic [9:0] req0_col;
  logic       req1_valid, req1_write, req1_ready;
  logic [1:0] req1_bg, req1_ba;
  logic [9:0] req1_col;
  logic       cas_valid, cas_write, busy;
  logic [1:0] cas_bg, cas_ba, dbg_state;
  logic [9:0] cas_col;

  ddr4_cas_scheduler dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en),
    .cfg_cl(cfg_cl), .cfg_cwl(cfg_cwl), .cfg_tccd_l(cfg_tccd_l),
    .cfg_twtr_s(cfg_twtr_s), .cfg_twtr_l(cfg_twtr_l),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_bg(req0_bg),
    .req0_ba(req0_ba), .req0_col(req0_col), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_bg(req1_bg),
    .req1_ba(req1_ba), .req1_col(req1_col), .req1_ready(req1_ready),
    .cas_valid(cas_valid), .cas_write(cas_write), .cas_bg(cas_bg),
    .cas_ba(cas_ba), .cas_col(cas_col), .busy(busy), .dbg_state(dbg_state)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  int          now      = 0;
  logic [14:0] exp_q[$];
  bit          cas_seen, hs0, hs1;

  // reference model: cycle at which each resource becomes free again
  bit m_active, m_loading, m_prev_en, m_rr;
  int m_tccd_l, m_wtr_s, m_wtr_l, m_rtw;
  int fa_ccd_s, fa_wtr_any, fa_rtw;
  int fa_ccd_bg[4];
  int fa_wtr_bg[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_active = 0; m_loading = 0; m_prev_en = 0; m_rr = 0;
    fa_ccd_s = 0; fa_wtr_any = 0; fa_rtw = 0;
    for (int g = 0; g < 4; g++) begin
      fa_ccd_bg[g] = 0;
      fa_wtr_bg[g] = 0;
    end
  endtask

  function automatic bit m_eligible(input logic w, input logic [1:0] bg);
    if (now < fa_ccd_s || now < fa_ccd_bg[bg]) return 1'b0;
    if (w) return now >= fa_rtw;
    return (now >= fa_wtr_any) && (now >= fa_wtr_bg[bg]);
  endfunction

  function automatic bit m_busy();
    bit b = (fa_ccd_s > now) || (fa_wtr_any > now) || (fa_rtw > now);
    for (int g = 0; g < 4; g++) b = b || (fa_ccd_bg[g] > now) || (fa_wtr_bg[g] > now);
    return b;
  endfunction

  task automatic model_grant(input logic w, input logic [1:0] bg, input logic [1:0] ba, input logic [9:0] col);
    fa_ccd_s      = imax(fa_ccd_s, now + TCCD_S);
    fa_ccd_bg[bg] = imax(fa_ccd_bg[bg], now + m_tccd_l);
    if (w) begin
      fa_wtr_bg[bg] = imax(fa_wtr_bg[bg], now + m_wtr_l);
      fa_wtr_any    = imax(fa_wtr_any, now + m_wtr_s);
    end else begin
      fa_rtw = imax(fa_rtw, now + m_rtw);
    end
    exp_q.push_back({w, bg, ba, col});
  endtask

  // one clock: check readies against the model, advance, then check the CAS output and busy
  task automatic step();
    bit ok, e0, e1, g0, g1;
    logic [14:0] exp;
    #1;
    ok = m_active && cfg_en && !rst;
    e0 = req0_valid && m_eligible(req0_write, req0_bg);
    e1 = req1_valid && m_eligible(req1_write, req1_bg);
    g0 = ok && e0 && (!e1 || !m_rr);
    g1 = ok && e1 && (!e0 || m_rr);
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("one_ready", 32'(req0_ready & req1_ready), 32'(0));
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (g0) model_grant(req0_write, req0_bg, req0_ba, req0_col);
    if (g1) model_grant(req1_write, req1_bg, req1_ba, req1_col);
    if (g0) m_rr = 1;
    else if (g1) m_rr = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (m_active) begin
        if (!cfg_en) m_active = 0;
      end else if (m_loading) begin
        m_tccd_l = int'(cfg_tccd_l);
        m_wtr_s  = int'(cfg_cwl) + BL_HALF + int'(cfg_twtr_s);
        m_wtr_l  = int'(cfg_cwl) + BL_HALF + int'(cfg_twtr_l);
        m_rtw    = int'(cfg_cl) + BL_HALF + 2 - int'(cfg_cwl);
        if (m_rtw < 1) m_rtw = 1;
        m_loading = 0;
        m_active  = 1;
      end else if (cfg_en && !m_prev_en) begin
        m_loading = 1;
      end
      m_prev_en = cfg_en;
    end
    @(posedge clk);
    now++;
    @(negedge clk);
    cas_seen = cas_valid;
    check("cas_valid", 32'(cas_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      if (cas_valid) check("cas_fields", 32'({cas_write, cas_bg, cas_ba, cas_col}), 32'(exp));
    end
    check("busy", 32'(busy), 32'(m_busy()));
  endtask

  // driver tasks
  task automatic configure(input int cl, input int cwl, input int tccdl, input int twtrs, input int twtrl);
    req0_valid = 0;
    req1_valid = 0;
    cfg_en     = 0;
    step();
    for (int k = 0; k < 64 && busy; k++) step();
    cfg_cl = 5'(cl); cfg_cwl = 5'(cwl); cfg_tccd_l = 4'(tccdl);
    cfg_twtr_s = 4'(twtrs); cfg_twtr_l = 4'(twtrl);
    cfg_en = 1;
    step();
    step();
  endtask

  task automatic issue(input bit n, input bit w, input logic [1:0] bg, output int t);
    t = -1;
    if (n == 0) begin
      req0_valid = 1; req0_write = w; req0_bg = bg;
      req0_ba = 2'($urandom_range(0, 3)); req0_col = 10'($urandom_range(0, 1023));
    end else begin
      req1_valid = 1; req1_write = w; req1_bg = bg;
      req1_ba = 2'($urandom_range(0, 3)); req1_col = 10'($urandom_range(0, 1023));
    end
    for (int k = 0; k < 100; k++) begin
      step();
      if (cas_seen) begin
        t = now;
        break;
      end
    end
    check("issue_done", 32'(cas_seen), 32'(1));
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic rand_traffic(input int cycles, input bit toggle_en);
    for (int i = 0; i < cycles; i++) begin
      if (hs0 || $urandom_range(0, 7) == 0) begin
        req0_valid = ($urandom_range(0, 3) != 0); req0_write = 1'($urandom_range(0, 1));
        req0_bg = 2'($urandom_range(0, 3)); req0_ba = 2'($urandom_range(0, 3));
        req0_col = 10'($urandom_range(0, 1023));
      end
      if (hs1 || $urandom_range(0, 7) == 0) begin
        req1_valid = ($urandom_range(0, 3) != 0); req1_write = 1'($urandom_range(0, 1));
        req1_bg = 2'($urandom_range(0, 3)); req1_ba = 2'($urandom_range(0, 3));
        req1_col = 10'($urandom_range(0, 1023));
      end
      if (toggle_en && $urandom_range(0, 99) == 0) begin
        cfg_en = ~cfg_en;
        if (!cfg_en) begin
          cfg_cl = 5'($urandom_range(9, 24)); cfg_cwl = 5'($urandom_range(9, 18));
          cfg_tccd_l = 4'($urandom_range(4, 8));
        end
      end
      step();
      hs0 = hs0 && !rst;
      hs1 = hs1 && !rst;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, t2, t3, n_cas, last_t, k;
    logic [1:0] prev_bg;
    rst = 1; cfg_en = 0;
    cfg_cl = 0; cfg_cwl = 0; cfg_tccd_l = 0; cfg_twtr_s = 0; cfg_twtr_l = 0;
    req0_valid = 0; req0_write = 0; req0_bg = 0; req0_ba = 0; req0_col = 0;
    req1_valid = 0; req1_write = 0; req1_bg = 0; req1_ba = 0; req1_col = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_cas_valid", 32'(cas_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cas_col", 32'(cas_col), 32'(0));
    rst = 0;
    step();

    // same-BG and cross-BG read spacing
    configure(16, 12, 6, 3, 9);
    issue(0, 0, 2'd0, t1); issue(0, 0, 2'd0, t2); issue(0, 0, 2'd0, t3);
    check("gap_rd_same_bg", 32'(t2 - t1), 32'(6));
    check("gap_rd_same_bg2", 32'(t3 - t2), 32'(6));
    issue(0, 0, 2'd1, t1); issue(0, 0, 2'd0, t2);
    check("gap_rd_diff_bg", 32'(t1 - t3), 32'(4));
    check("gap_rd_diff_bg2", 32'(t2 - t1), 32'(4));

    // write-to-read, same and different BG
    issue(0, 1, 2'd1, t1); issue(0, 0, 2'd1, t2);
    check("gap_wtr_l", 32'(t2 - t1), 32'(25));
    issue(0, 1, 2'd1, t1); issue(0, 0, 2'd2, t2);
    check("gap_wtr_s", 32'(t2 - t1), 32'(19));

    // read-to-write, normal and clamped
    issue(0, 0, 2'd0, t1); issue(0, 1, 2'd0, t2);
    check("gap_rtw", 32'(t2 - t1), 32'(10));
    configure(9, 18, 4, 3, 9);
    issue(0, 0, 2'd0, t1); issue(0, 1, 2'd1, t2);
    check("gap_rtw_clamp", 32'(t2 - t1), 32'(4));

    // round-robin between two continuously valid readers
    configure(9, 18, 4, 3, 9);
    req0_valid = 1; req0_write = 0; req0_bg = 2'd0;
    req1_valid = 1; req1_write = 0; req1_bg = 2'd1;
    n_cas = 0; last_t = 0; prev_bg = 2'd0;
    for (int i = 0; i < 40; i++) begin
      req0_col = 10'($urandom_range(0, 1023)); req1_col = 10'($urandom_range(0, 1023));
      step();
      if (cas_seen) begin
        if (n_cas > 0) begin
          check("rr_alternate", 32'(cas_bg), 32'(prev_bg ^ 2'd1));
          check("rr_gap", 32'(now - last_t), 32'(4));
        end
        prev_bg = cas_bg; last_t = now; n_cas++;
      end
    end
    check("rr_count", 32'(n_cas), 32'(10));

    // disable with a pending request, then re-enable with tCCD_L=8
    configure(16, 12, 6, 3, 9);
    issue(0, 0, 2'd0, t1);
    req0_valid = 1; req0_write = 0; req0_bg = 2'd0;
    cfg_en = 0;
    n_cas = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cas_seen) n_cas++;
    end
    check("off_no_cas", 32'(n_cas), 32'(0));
    cfg_tccd_l = 4'd8;
    cfg_en = 1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      k++;
      if (cas_seen) break;
    end
    check("load_latency", 32'(k), 32'(3));
    t1 = now;
    issue(0, 0, 2'd0, t2);
    check("gap_tccd_l8", 32'(t2 - t1), 32'(8));

    // randomized traffic over several configurations
    for (int c = 0; c < 4; c++) begin
      configure($urandom_range(9, 24), $urandom_range(9, 18), $urandom_range(4, 8),
                $urandom_range(2, 8), $urandom_range(4, 12));
      rand_traffic(300, 1'b1);
    end

    // reset in the middle of traffic
    configure(16, 12, 6, 3, 9);
    rand_traffic(30, 1'b0);
    rst = 1; cfg_en = 0;
    step(); step();
    check("rst_mid_cas_valid", 32'(cas_valid), 32'(0));
    check("rst_mid_cas_write", 32'(cas_write), 32'(0));
    check("rst_mid_cas_addr", 32'({cas_bg, cas_ba, cas_col}), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    rst = 0;
    step();
    check("rst_after_busy", 32'(busy), 32'(0));
    n_cas = 0;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1; req0_bg = 2'($urandom_range(0, 3));
      step();
      if (cas_seen) n_cas++;
    end
    check("rst_no_cas_until_en", 32'(n_cas), 32'(0));
    cfg_en = 1;
    rand_traffic(60, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
